wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Architectural state block for the RV64 pipeline: 32 x 64-bit GPR file plus a small machine-mode CSR file.
- Serves the decode stage's combinational read requests (rs1, rs2, CSR) and accepts writes from the writeback stage.
- Maintains the free-running mcycle counter and the retire-driven minstret counter.
- Decode performs its own forwarding from EX/MEM/MEM-WB, so this block provides no internal read bypass.

Parameters:
- XLEN, 64, data width of GPRs and CSRs.
- NREG, 32, number of GPRs; the address width is 5.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
- rs1_addr_i  input  5  GPR read port 1 address, from decode.
- rs2_addr_i  input  5  GPR read port 2 address, from decode.
- rs1_data_o  output  64  GPR read port 1 data.
- rs2_data_o  output  64  GPR read port 2 data.
- csr_raddr_i  input  12  CSR read address, from decode.
- csr_data_o  output  64  CSR read data.
- wb_rd_addr_i  input  5  GPR write address.
- wb_wdata_i  input  64  GPR write data.
- wb_wreg_i  input  1  GPR write enable (1 = write).
- wb_csr_waddr_i  input  12  CSR write address.
- wb_csr_wdata_i  input  64  CSR write data.
- wb_csr_wreg_i  input  1  CSR write enable.
- retire_i  input  1  one instruction retired this cycle.

Behaviour:
- Reset (rst=0, asynchronous): all GPRs, mstatus, mtvec, mscratch, mepc, mcause, mcycle and minstret clear to 0 immediately, with no clock required.
  - Read outputs are combinational, so during reset they show 0 for every address.
  - All writes and increments are blocked while rst=0.
  - Release is synchronous to the next rising edge: the first update happens on the first rising edge after rst returns to 1.
- GPR reads are combinational, with zero latency.
  - Address 0 always reads 0.
  - No write-through: a read of the same address as a same-cycle write returns the old value; the new value is visible the cycle after the edge.
- GPR write: on the rising edge, if wb_wreg_i=1 and wb_rd_addr_i!=0, reg[wb_rd_addr_i] <= wb_wdata_i. Writes to x0 are discarded.
- Implemented CSRs (address: name, access):
  - 0x300 mstatus, RW full 64 bits.
  - 0x305 mtvec, RW.
  - 0x340 mscratch, RW.
  - 0x341 mepc, RW; bits[1:0] are forced to 0 on write.
  - 0x342 mcause, RW.
  - 0xB00 mcycle, RW.
  - 0xB02 minstret, RW.
  - 0xC00 cycle, read-only alias of mcycle.
  - 0xC02 instret, read-only alias of minstret.
- CSR read: combinational. Unimplemented addresses read 0. Same-cycle write is not bypassed.
- CSR write: on the rising edge when wb_csr_wreg_i=1.
  - Writes to unimplemented addresses are ignored.
  - Writes to the read-only aliases 0xC00 and 0xC02 are ignored.
- mcycle:
  - Increments by 1 every cycle out of reset, wrapping 2^64-1 -> 0.
  - If a write to 0xB00 happens in the same cycle, the write wins: mcycle <= wdata, with no +1 that cycle.
- minstret:
  - Increments by 1 on each edge with retire_i=1, wrapping at 2^64.
  - A same-cycle write to 0xB02 wins over the increment.
- Simultaneous GPR write and CSR write in one cycle are independent; both take effect.

Test Plan:
1. Reset/zero: hold rst=0 and drive random GPR/CSR writes -> every read returns 0. Release rst, then write x0=0xDEAD -> rs1_addr_i=0 reads 0.
2. GPR write/read: write x5=0x0123_4567_89AB_CDEF with rs1_addr_i=5 in the same cycle -> rs1_data_o is 0 in that cycle and 0x0123_4567_89AB_CDEF in the next. rs2_addr_i=5 returns the same value.
3. CSR access: write mepc=0x8000_0007 -> reads 0x8000_0004.
   - Write 0x7C0=0xFF -> 0x7C0 reads 0.
   - Write 0xC00=5 -> mcycle is unaffected.
4. mcycle: 10 cycles after reset release, 0xB00 reads 10.
   - Write mcycle=0xFFFF_FFFF_FFFF_FFFF -> the next cycle reads all-ones, the cycle after reads 0.
   - 0xC00 matches 0xB00 throughout.
5. minstret: pulse retire_i 3 times non-consecutively -> 0xB02 reads 3.
   - Write 0xB02=100 with retire_i=1 in the same cycle -> reads 100, not 101.
6. Mid-operation reset: assert rst asynchronously between edges after x7=0x55 and mcycle=0x40 -> x7 and mcycle read 0 before the next edge. After release, mcycle counts from 0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
//   Bundles the decode-side read ports and the writeback-side write ports of
//   the architectural register block.
//
//   Decode read side : rs1_addr_i/rs2_addr_i -> rs1_data_o/rs2_data_o,
//                      csr_raddr_i -> csr_data_o (all combinational)
//   Writeback side   : wb_rd_addr_i/wb_wdata_i/wb_wreg_i (GPR write),
//                      wb_csr_waddr_i/wb_csr_wdata_i/wb_csr_wreg_i (CSR write),
//                      retire_i (minstret increment)
//
//   master : pipeline side (drives addresses, write data, enables)
//   slave  : wb_regfile (drives read data)
// ---------------------------------------------------------------------------
interface wb_regfile_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1_addr_i;
    logic [AW-1:0]   rs2_addr_i;
    logic [XLEN-1:0] rs1_data_o;
    logic [XLEN-1:0] rs2_data_o;
    logic [11:0]     csr_raddr_i;
    logic [XLEN-1:0] csr_data_o;
    logic [AW-1:0]   wb_rd_addr_i;
    logic [XLEN-1:0] wb_wdata_i;
    logic            wb_wreg_i;
    logic [11:0]     wb_csr_waddr_i;
    logic [XLEN-1:0] wb_csr_wdata_i;
    logic            wb_csr_wreg_i;
    logic            retire_i;

    modport master (
        output rs1_addr_i, rs2_addr_i, csr_raddr_i,
        output wb_rd_addr_i, wb_wdata_i, wb_wreg_i,
        output wb_csr_waddr_i, wb_csr_wdata_i, wb_csr_wreg_i,
        output retire_i,
        input  rs1_data_o, rs2_data_o, csr_data_o
    );

    modport slave (
        input  rs1_addr_i, rs2_addr_i, csr_raddr_i,
        input  wb_rd_addr_i, wb_wdata_i, wb_wreg_i,
        input  wb_csr_waddr_i, wb_csr_wdata_i, wb_csr_wreg_i,
        input  retire_i,
        output rs1_data_o, rs2_data_o, csr_data_o
    );
endinterface

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Architectural state for the RV64 pipeline: 32 x XLEN GPRs plus the
//   machine-mode CSRs mstatus, mtvec, mscratch, mepc, mcause, mcycle and
//   minstret (with user read-only aliases cycle/instret).
//
//   Ports:
//     clk  - system clock, all state updates on the rising edge
//     rst  - asynchronous active-low reset; clears every register at once
//     bus  - wb_regfile_if.slave: combinational GPR/CSR reads for decode,
//            GPR/CSR writes and retire pulse from writeback
//
//   Reads have no bypass: decode forwards in-flight results itself, so a
//   same-cycle write is only visible after the edge.
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;

    logic [XLEN-1:0] gpr [NREG];

    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] minstret;

    logic [XLEN-1:0] csr_rdata;

    // -----------------------------------------------------------------------
    // GPR file. Entry 0 is never written, so it stays at its reset value.
    // -----------------------------------------------------------------------
    // NOTE: this array is architectural state that must read 0 straight out
    // of reset, so it is reset like a flop bank rather than left as RAM.
    always_ff @(posedge clk or negedge rst) begin : gpr_write
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr[i] <= '0;
            end
        end else if (bus.wb_wreg_i && (bus.wb_rd_addr_i != '0)) begin
            // NOTE: non-blocking so every reader in this edge sees the old value.
            gpr[bus.wb_rd_addr_i] <= bus.wb_wdata_i;
        end
    end

    assign bus.rs1_data_o = (bus.rs1_addr_i == '0) ? '0 : gpr[bus.rs1_addr_i];
    assign bus.rs2_data_o = (bus.rs2_addr_i == '0) ? '0 : gpr[bus.rs2_addr_i];

    // -----------------------------------------------------------------------
    // CSR state. The counters advance first; an explicit CSR write later in
    // the same block overrides the increment, so software writes win.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin : csr_write
        if (!rst) begin
            mstatus  <= '0;
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle <= mcycle + XLEN'(1);
            if (bus.retire_i) begin
                minstret <= minstret + XLEN'(1);
            end

            if (bus.wb_csr_wreg_i) begin
                // Unimplemented addresses and the cycle/instret aliases fall
                // through to the default and are dropped.
                unique case (bus.wb_csr_waddr_i)
                    CSR_MSTATUS:  mstatus  <= bus.wb_csr_wdata_i;
                    CSR_MTVEC:    mtvec    <= bus.wb_csr_wdata_i;
                    CSR_MSCRATCH: mscratch <= bus.wb_csr_wdata_i;
                    CSR_MEPC:     mepc     <= {bus.wb_csr_wdata_i[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:   mcause   <= bus.wb_csr_wdata_i;
                    CSR_MCYCLE:   mcycle   <= bus.wb_csr_wdata_i;
                    CSR_MINSTRET: minstret <= bus.wb_csr_wdata_i;
                    default:      ;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // CSR read mux, unimplemented addresses read 0.
    // -----------------------------------------------------------------------
    always_comb begin : csr_read
        // NOTE: default first so no path through the case leaves csr_rdata unassigned.
        csr_rdata = '0;
        unique case (bus.csr_raddr_i)
            CSR_MSTATUS:  csr_rdata = mstatus;
            CSR_MTVEC:    csr_rdata = mtvec;
            CSR_MSCRATCH: csr_rdata = mscratch;
            CSR_MEPC:     csr_rdata = mepc;
            CSR_MCAUSE:   csr_rdata = mcause;
            CSR_MCYCLE,
            CSR_CYCLE:    csr_rdata = mcycle;
            CSR_MINSTRET,
            CSR_INSTRET:  csr_rdata = minstret;
            default:      csr_rdata = '0;
        endcase
    end

    assign bus.csr_data_o = csr_rdata;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Directed checks with hand-computed values followed by a randomized phase.
//   A behavioural model of the architectural state is compared against the
//   read ports on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_regfile_if #(.XLEN(64), .AW(5)) bus ();

    wb_regfile #(.XLEN(64), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit done  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_gpr [32];
    logic [63:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 64'd0;
            m_mstatus = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
            m_mcause = 0; m_mcycle = 0; m_minstret = 0;
        end else begin
            if (bus.wb_wreg_i && bus.wb_rd_addr_i != 5'd0)
                m_gpr[bus.wb_rd_addr_i] = bus.wb_wdata_i;
            m_mcycle   = m_mcycle + 64'd1;
            m_minstret = m_minstret + (bus.retire_i ? 64'd1 : 64'd0);
            if (bus.wb_csr_wreg_i) begin
                case (bus.wb_csr_waddr_i)
                    12'h300: m_mstatus  = bus.wb_csr_wdata_i;
                    12'h305: m_mtvec    = bus.wb_csr_wdata_i;
                    12'h340: m_mscratch = bus.wb_csr_wdata_i;
                    12'h341: m_mepc     = bus.wb_csr_wdata_i & ~64'd3;
                    12'h342: m_mcause   = bus.wb_csr_wdata_i;
                    12'hB00: m_mcycle   = bus.wb_csr_wdata_i;
                    12'hB02: m_minstret = bus.wb_csr_wdata_i;
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [63:0] m_gpr_read(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : m_gpr[a];
    endfunction

    function automatic logic [63:0] m_csr_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_mcycle;
            12'hB02, 12'hC02: return m_minstret;
            default: return 64'd0;
        endcase
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!done) begin
            check("rs1_model", bus.rs1_data_o, m_gpr_read(bus.rs1_addr_i));
            check("rs2_model", bus.rs2_data_o, m_gpr_read(bus.rs2_addr_i));
            check("csr_model", bus.csr_data_o, m_csr_read(bus.csr_raddr_i));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [11:0] csr_list [11] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'h7C0, 12'h301};

    function automatic logic [11:0] pick_csr();
        if ($urandom_range(0, 3) == 0) return 12'($urandom);
        return csr_list[$urandom_range(0, 10)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_wreg_i     = 1'b0;
        bus.wb_csr_wreg_i = 1'b0;
        bus.retire_i      = 1'b0;
    endtask

    initial begin
        bus.rs1_addr_i = '0; bus.rs2_addr_i = '0; bus.csr_raddr_i = '0;
        bus.wb_rd_addr_i = '0; bus.wb_wdata_i = '0; bus.wb_csr_waddr_i = '0;
        bus.wb_csr_wdata_i = '0;
        idle_inputs();
        #1 rst = 1'b0;

        // 1. Writes held off during reset; every read is 0.
        for (int i = 0; i < 8; i++) begin
            bus.wb_wreg_i      = 1'b1;
            bus.wb_rd_addr_i   = 5'($urandom_range(1, 31));
            bus.wb_wdata_i     = {$urandom, $urandom};
            bus.wb_csr_wreg_i  = 1'b1;
            bus.wb_csr_waddr_i = csr_list[i];
            bus.wb_csr_wdata_i = {$urandom, $urandom};
            bus.retire_i       = 1'b1;
            bus.rs1_addr_i     = bus.wb_rd_addr_i;
            bus.rs2_addr_i     = 5'($urandom);
            bus.csr_raddr_i    = csr_list[i];
            #1;
            check("reset_rs1", bus.rs1_data_o, 64'd0);
            check("reset_rs2", bus.rs2_data_o, 64'd0);
            check("reset_csr", bus.csr_data_o, 64'd0);
            tick();
        end
        idle_inputs();
        rst = 1'b1;

        // x0 write discarded (edge 1)
        bus.wb_wreg_i = 1'b1; bus.wb_rd_addr_i = 5'd0; bus.wb_wdata_i = 64'hDEAD;
        bus.rs1_addr_i = 5'd0;
        tick();
        idle_inputs();
        #1 check("x0_zero", bus.rs1_data_o, 64'd0);

        // 2. GPR write, no write-through (edge 2)
        bus.wb_wreg_i = 1'b1; bus.wb_rd_addr_i = 5'd5; bus.wb_wdata_i = 64'h0123_4567_89AB_CDEF;
        bus.rs1_addr_i = 5'd5; bus.rs2_addr_i = 5'd5;
        #1 check("x5_same_cycle", bus.rs1_data_o, 64'd0);
        tick();
        idle_inputs();
        #1;
        check("x5_rs1", bus.rs1_data_o, 64'h0123_4567_89AB_CDEF);
        check("x5_rs2", bus.rs2_data_o, 64'h0123_4567_89AB_CDEF);

        // 4a. edges 3..10 -> mcycle = 10
        repeat (8) tick();
        bus.csr_raddr_i = 12'hB00;
        #1 check("mcycle_10", bus.csr_data_o, 64'd10);
        bus.csr_raddr_i = 12'hC00;
        #1 check("cycle_10", bus.csr_data_o, 64'd10);

        // 3. CSR access (edges 11..13)
        bus.wb_csr_wreg_i = 1'b1; bus.wb_csr_waddr_i = 12'h341; bus.wb_csr_wdata_i = 64'h8000_0007;
        tick();
        bus.wb_csr_waddr_i = 12'h7C0; bus.wb_csr_wdata_i = 64'hFF;
        bus.csr_raddr_i = 12'h341;
        #1 check("mepc_align", bus.csr_data_o, 64'h8000_0004);
        tick();
        bus.wb_csr_waddr_i = 12'hC00; bus.wb_csr_wdata_i = 64'd5;
        bus.csr_raddr_i = 12'h7C0;
        #1 check("unimpl_zero", bus.csr_data_o, 64'd0);
        tick();
        idle_inputs();
        bus.csr_raddr_i = 12'hB00;
        #1 check("cycle_ro", bus.csr_data_o, 64'd13);

        // 4b. mcycle wrap (edges 14, 15)
        bus.wb_csr_wreg_i = 1'b1; bus.wb_csr_waddr_i = 12'hB00; bus.wb_csr_wdata_i = '1;
        tick();
        idle_inputs();
        #1 check("mcycle_ones", bus.csr_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        #1 check("mcycle_wrap", bus.csr_data_o, 64'd0);
        bus.csr_raddr_i = 12'hC00;
        #1 check("cycle_wrap", bus.csr_data_o, 64'd0);

        // 5. minstret
        for (int i = 0; i < 3; i++) begin
            bus.retire_i = 1'b1; tick();
            bus.retire_i = 1'b0; tick();
        end
        bus.csr_raddr_i = 12'hB02;
        #1 check("minstret_3", bus.csr_data_o, 64'd3);
        bus.csr_raddr_i = 12'hC02;
        #1 check("instret_3", bus.csr_data_o, 64'd3);
        bus.retire_i = 1'b1;
        bus.wb_csr_wreg_i = 1'b1; bus.wb_csr_waddr_i = 12'hB02; bus.wb_csr_wdata_i = 64'd100;
        tick();
        idle_inputs();
        bus.csr_raddr_i = 12'hB02;
        #1 check("minstret_wr_wins", bus.csr_data_o, 64'd100);

        // 6. Mid-operation async reset
        bus.wb_wreg_i = 1'b1; bus.wb_rd_addr_i = 5'd7; bus.wb_wdata_i = 64'h55;
        bus.wb_csr_wreg_i = 1'b1; bus.wb_csr_waddr_i = 12'hB00; bus.wb_csr_wdata_i = 64'h40;
        tick();
        idle_inputs();
        bus.rs1_addr_i = 5'd7; bus.csr_raddr_i = 12'hB00;
        #1;
        check("x7_set", bus.rs1_data_o, 64'h55);
        check("mcycle_40", bus.csr_data_o, 64'h40);
        #1 rst = 1'b0;
        #1;
        check("x7_async_clr", bus.rs1_data_o, 64'd0);
        check("mcycle_async_clr", bus.csr_data_o, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        #1 check("mcycle_restart", bus.csr_data_o, 64'd1);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            bus.rs1_addr_i     = 5'($urandom);
            bus.rs2_addr_i     = ($urandom_range(0, 3) == 0) ? bus.wb_rd_addr_i : 5'($urandom);
            bus.csr_raddr_i    = pick_csr();
            bus.wb_wreg_i      = 1'($urandom_range(0, 1));
            bus.wb_rd_addr_i   = 5'($urandom);
            bus.wb_wdata_i     = {$urandom, $urandom};
            bus.wb_csr_wreg_i  = ($urandom_range(0, 2) == 0);
            bus.wb_csr_waddr_i = pick_csr();
            bus.wb_csr_wdata_i = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE
                                                               : {$urandom, $urandom};
            bus.retire_i       = 1'($urandom_range(0, 1));
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b0;
            end
            tick();
        end

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
